mux_sel_pipe: RTL and testbench

- Parametrised successor to the combinational register-destination/ALU-operand selectors in the multicycle datapath.
- Selects one of N_DATA data words or one of two hard-wired constants (default 29 = $sp, 31 = $ra).
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so the control FSM can stall the consumer without losing a selection.
- Flags out-of-range selector codes.

---
 rtl/mux_pkg.sv | 25 ++
 rtl/mux_sel_pipe_skid_reg.sv | 71 +++++++
 rtl/mux_sel_pipe.sv | 78 +++++++
 tb/tb_mux_sel_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the register-destination / operand selector.
package mux_pkg;

    // Hard-wired register numbers: stack pointer and return address.
    localparam int unsigned SP_REG = 29;
    localparam int unsigned RA_REG = 31;

    // Occupancy of the output register plus skid entry.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    // Selector code that picks the first constant.
    function automatic int unsigned const_code_a(input int unsigned n_data);
        return n_data;
    endfunction

    // Selector code that picks the second constant.
    function automatic int unsigned const_code_b(input int unsigned n_data);
        return n_data + 1;
    endfunction

endpackage

// File: rtl/mux_sel_pipe_skid_reg.sv
// WIDTH-wide valid/ready output register with a one-entry skid buffer.
// in_ready is registered and is low only while both entries are full.
module skid_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    occ_state_t       state;
    logic [WIDTH-1:0] skid;
    logic             accept;
    logic             deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    // Occupancy FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && deliver) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid     <= in_data;
                        in_ready <= 1'b0;
                        state    <= OCC_TWO;
                    end else if (deliver) begin
                        out_valid <= 1'b0;
                        state     <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (deliver) begin
                        out_data <= skid;
                        in_ready <= 1'b1;
                        state    <= OCC_ONE;
                    end
                end
                default: begin
                    state     <= OCC_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Selects one of N_DATA words or one of two constants, registers the result
// behind a valid/ready skid stage and flags out-of-range selector codes.
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_DATA  = 3,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned CONST_A = SP_REG,
    parameter int unsigned CONST_B = RA_REG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        selector,
    input  logic [N_DATA*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        data_out,
    output logic                    sel_err,
    input  logic                    err_clr
);

    localparam int unsigned CODE_A = const_code_a(N_DATA);
    localparam int unsigned CODE_B = const_code_b(N_DATA);

    logic [WIDTH-1:0] sel_word;
    logic             sel_bad;
    logic             accept;

    assign accept = in_valid && in_ready;

    // Selector decode: data words, then the two constants, else fall back to data_0.
    always_comb begin
        sel_word = data_in[WIDTH-1:0];
        sel_bad  = 1'b1;
        for (int unsigned i = 0; i < N_DATA; i++) begin
            if (selector == SEL_W'(i)) begin
                sel_word = data_in[i*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
        if (selector == SEL_W'(CODE_A)) begin
            sel_word = WIDTH'(CONST_A);
            sel_bad  = 1'b0;
        end
        if (selector == SEL_W'(CODE_B)) begin
            sel_word = WIDTH'(CONST_B);
            sel_bad  = 1'b0;
        end
    end

    // Sticky error flag; a new bad accept outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && sel_bad) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    skid_reg #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (sel_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (data_out)
    );

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Self-checking bench for mux_sel_pipe: directed scenarios plus a FIFO scoreboard.
module tb_mux_sel_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned N_DATA = 3;
    localparam int unsigned SEL_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        selector;
    logic [N_DATA*WIDTH-1:0] data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        data_out;
    logic                    sel_err;
    logic                    err_clr;

    // Second instance for the narrow / wide-fanin parameter set.
    logic                    p_in_valid;
    logic                    p_in_ready;
    logic [2:0]              p_selector;
    logic [39:0]             p_data_in;
    logic                    p_out_valid;
    logic                    p_out_ready;
    logic [7:0]              p_data_out;
    logic                    p_sel_err;
    logic                    p_err_clr;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    mux_sel_pipe #(.WIDTH(WIDTH), .N_DATA(N_DATA), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .selector(selector), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .sel_err(sel_err),
        .err_clr(err_clr)
    );

    mux_sel_pipe #(.WIDTH(8), .N_DATA(5), .SEL_W(3)) dut_p (
        .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .selector(p_selector), .data_in(p_data_in), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .data_out(p_data_out), .sel_err(p_sel_err),
        .err_clr(p_err_clr)
    );

    // Reference selection for the default configuration.
    function automatic logic [WIDTH-1:0] ref_sel(input logic [SEL_W-1:0] code,
                                                 input logic [N_DATA*WIDTH-1:0] d);
        case (code)
            3'd0:    return d[31:0];
            3'd1:    return d[63:32];
            3'd2:    return d[95:64];
            3'd3:    return 32'd29;
            3'd4:    return 32'd31;
            default: return d[31:0];
        endcase
    endfunction

    // Scoreboard: mid-cycle, inputs/outputs are stable and describe the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got %h with empty scoreboard", data_out);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = sb.pop_front();
                    if (data_out !== e) begin
                        bad++;
                        $display("FAIL sb_data: got %h expected %h", data_out, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_sel(selector, data_in));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || data_out !== '0 || in_ready !== 1'b1 || sel_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_defaults: ov=%b do=%h ir=%b err=%b expected 0 0 1 0",
                     out_valid, data_out, in_ready, sel_err);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] exp_v [5];
        exp_v[0] = 32'hA; exp_v[1] = 32'hB; exp_v[2] = 32'hC;
        exp_v[3] = 32'd29; exp_v[4] = 32'd31;
        data_in   = {32'hC, 32'hB, 32'hA};
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            selector = SEL_W'(c);
            step();
            total++;
            if (out_valid !== 1'b1 || data_out !== exp_v[c] || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_code%0d: ov=%b do=%h ir=%b expected 1 %h 1",
                         c, out_valid, data_out, in_ready, exp_v[c]);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 3'd0;
        step();
        selector  = 3'd1;
        step();
        in_valid  = 1'b0;
        total++;
        if (in_ready !== 1'b0 || data_out !== 32'hA || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full: ir=%b do=%h ov=%b expected 0 0000000a 1", in_ready, data_out, out_valid);
        end
        step();
        total++;
        if (data_out !== 32'hA || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stable: do=%h ir=%b expected 0000000a 0", data_out, in_ready);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (data_out !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second: do=%h ov=%b ir=%b expected 0000000b 1 1", data_out, out_valid, in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        selector  = 3'd5;
        step();
        in_valid  = 1'b0;
        total++;
        if (data_out !== 32'hA || sel_err !== 1'b1) begin
            bad++;
            $display("FAIL oor_set: do=%h err=%b expected 0000000a 1", data_out, sel_err);
        end
        step(); step();
        total++;
        if (sel_err !== 1'b1) begin
            bad++;
            $display("FAIL oor_sticky: err=%b expected 1", sel_err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++;
        if (sel_err !== 1'b0) begin
            bad++;
            $display("FAIL oor_clear: err=%b expected 0", sel_err);
        end
        in_valid = 1'b1;
        selector = 3'd7;
        err_clr  = 1'b1;
        step();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        total++;
        if (sel_err !== 1'b1) begin
            bad++;
            $display("FAIL oor_set_wins: err=%b expected 1", sel_err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
    endtask

    task automatic test_ignore_invalid();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            selector = (i % 2 == 0) ? 3'd6 : 3'd0;
            data_in  = {3{32'(i) ^ 32'h5A5A_0000}};
            step();
            total++;
            if (out_valid !== 1'b0 || sel_err !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL ignore_%0d: ov=%b err=%b ir=%b expected 0 0 1",
                         i, out_valid, sel_err, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            selector  = SEL_W'($urandom_range(0, 7));
            data_in   = {$urandom(), $urandom(), $urandom()};
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();
        total++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: left=%0d ov=%b expected 0 0", sb.size(), out_valid);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_stalled();
        data_in   = {32'hC, 32'hB, 32'hA};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        selector  = 3'd5;
        step();
        selector  = 3'd2;
        step();
        in_valid  = 1'b0;
        total++;
        if (in_ready !== 1'b0 || sel_err !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: ir=%b err=%b expected 0 1", in_ready, sel_err);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || data_out !== '0 || in_ready !== 1'b1 || sel_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: ov=%b do=%h ir=%b err=%b expected 0 0 1 0",
                     out_valid, data_out, in_ready, sel_err);
        end
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_discard: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_param();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'd29; exp_v[1] = 8'd31; exp_v[2] = 8'h11;
        p_data_in   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        p_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            p_in_valid = 1'b1;
            p_selector = 3'(c + 5);
            step();
            total++;
            if (p_out_valid !== 1'b1 || p_data_out !== exp_v[c]) begin
                bad++;
                $display("FAIL param_code%0d: ov=%b do=%h expected 1 %h",
                         c + 5, p_out_valid, p_data_out, exp_v[c]);
            end
            total++;
            if (p_sel_err !== (c == 2)) begin
                bad++;
                $display("FAIL param_err%0d: err=%b expected %b", c + 5, p_sel_err, (c == 2));
            end
        end
        p_in_valid = 1'b1;
        p_selector = 3'd4;
        step();
        p_in_valid = 1'b0;
        total++;
        if (p_data_out !== 8'h55) begin
            bad++;
            $display("FAIL param_data4: do=%h expected 55", p_data_out);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; selector = '0; data_in = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        p_in_valid = 1'b0; p_selector = '0; p_data_in = '0;
        p_out_ready = 1'b0; p_err_clr = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_ignore_invalid();
        test_back_to_back();
        test_reset_stalled();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
